// File: rtl/sort_array_unsigned_sel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sort_pkg                                                     |
// | Description : Shared constants and FSM state encoding for the in-place     |
// |               unsigned selection sorter (sort_array_unsigned_sel).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sort_pkg;

  localparam int c_n_default  = 10;  // number of elements
  localparam int c_dw_default = 4;   // element width
  localparam int c_aw_default = 4;   // pointer width
  localparam int c_state_w    = 3;

  // UNKN is never entered from a legal state; it only catches corrupted codes.
  typedef enum logic [c_state_w-1:0] {
    INI   = 3'd0,
    LDMIN = 3'd1,
    SCAN  = 3'd2,
    SWAP1 = 3'd3,
    SWAP2 = 3'd4,
    DONE  = 3'd5,
    UNKN  = 3'd7
  } state_t;

endpackage : sort_pkg
`default_nettype wire

// File: rtl/sort_array_unsigned_sel_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : sort_array_unsigned_sel_if                                   |
// | Description : Control and memory-access bundle between the sorter and the  |
// |               block that owns array M.                                     |
// |   master (sorter) : in  Start, Ack, Ms_of_I, Ms_of_J                       |
// |                     out I, J, Ms_Write, W_Addr, W_Data, Done               |
// |                     out Swap_Count (only with SORT_SWAP_COUNT_EN)          |
// |   slave  (M owner): the mirror image                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface sort_array_unsigned_sel_if #(
  parameter int DW = 4,
  parameter int AW = 4
) ();

  logic          Start;
  logic          Ack;
  logic [DW-1:0] Ms_of_I;
  logic [DW-1:0] Ms_of_J;
  logic [AW-1:0] I;
  logic [AW-1:0] J;
  logic          Ms_Write;
  logic [AW-1:0] W_Addr;
  logic [DW-1:0] W_Data;
  logic          Done;
`ifdef SORT_SWAP_COUNT_EN
  logic [AW+2:0] Swap_Count;

  modport master (
    input  Start, Ack, Ms_of_I, Ms_of_J,
    output I, J, Ms_Write, W_Addr, W_Data, Done, Swap_Count
  );
  modport slave (
    output Start, Ack, Ms_of_I, Ms_of_J,
    input  I, J, Ms_Write, W_Addr, W_Data, Done, Swap_Count
  );
`else
  modport master (
    input  Start, Ack, Ms_of_I, Ms_of_J,
    output I, J, Ms_Write, W_Addr, W_Data, Done
  );
  modport slave (
    output Start, Ack, Ms_of_I, Ms_of_J,
    input  I, J, Ms_Write, W_Addr, W_Data, Done
  );
`endif

endinterface : sort_array_unsigned_sel_if
`default_nettype wire

// File: rtl/sort_array_unsigned_sel_min_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sel_sort_min_unit                                            |
// | Description : Combinational min-tracking step of one SCAN cycle.           |
// |   in  ms_of_j, min_val, j, min_idx, i                                      |
// |   out next_val/next_idx : running minimum after considering M[J]           |
// |       last              : J is the final element of the pass               |
// |       need_swap         : updated minimum is not already at position I     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sel_sort_min_unit #(
  parameter int N  = 10,
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic [DW-1:0] ms_of_j,
  input  logic [DW-1:0] min_val,
  input  logic [AW-1:0] j,
  input  logic [AW-1:0] min_idx,
  input  logic [AW-1:0] i,
  output logic [DW-1:0] next_val,
  output logic [AW-1:0] next_idx,
  output logic          last,
  output logic          need_swap
);

  localparam logic [AW-1:0] c_last_j = AW'(N - 1);

  logic w_less;

  // Strict '<' so that equal keys keep the earlier index (stable minimum).
  assign w_less    = (ms_of_j < min_val);
  assign next_val  = w_less ? ms_of_j : min_val;
  assign next_idx  = w_less ? j       : min_idx;
  assign last      = (j == c_last_j);
  assign need_swap = (next_idx != i);

endmodule : sel_sort_min_unit
`default_nettype wire

// File: rtl/sort_array_unsigned_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sort_array_unsigned_sel                                      |
// | Description : In-place ascending selection sort of an external unsigned    |
// |               array M[0..N-1]. Reads M[I], M[J] combinationally through    |
// |               the bus, writes one element per cycle during the two swap    |
// |               states. Done stays high until Ack.                           |
// |   Clk   : rising-edge clock                                                |
// |   Reset : asynchronous, active-high                                        |
// |   bus   : sort_array_unsigned_sel_if.master (Start/Ack, read pointers and  |
// |           data, write port, Done)                                          |
// |   Optional: SORT_SWAP_COUNT_EN adds bus.Swap_Count (swaps in last sort).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sort_array_unsigned_sel
  import sort_pkg::*;
#(
  parameter int N  = c_n_default,
  parameter int DW = c_dw_default,
  parameter int AW = c_aw_default
) (
  input  logic                        Clk,
  input  logic                        Reset,
  sort_array_unsigned_sel_if.master   bus
);

  localparam logic [AW-1:0] c_last_i = AW'(N - 2);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_i;
  logic [AW-1:0] r_j;
  logic [AW-1:0] r_min_idx;
  logic [DW-1:0] r_min_val;

  logic [DW-1:0] w_next_val;
  logic [AW-1:0] w_next_idx;
  logic          w_last;
  logic          w_need_swap;
  logic          w_ms_write;
  logic [AW-1:0] w_w_addr;
  logic [DW-1:0] w_w_data;
  logic          w_done;

  sel_sort_min_unit #(.N(N), .DW(DW), .AW(AW)) u_min_unit (
    .ms_of_j   (bus.Ms_of_J),
    .min_val   (r_min_val),
    .j         (r_j),
    .min_idx   (r_min_idx),
    .i         (r_i),
    .next_val  (w_next_val),
    .next_idx  (w_next_idx),
    .last      (w_last),
    .need_swap (w_need_swap)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= INI;
    else       r_state <= w_state_next;
  end

  // Next-state and Moore outputs. Writes happen only in SWAP1/SWAP2, so an
  // asynchronous reset drops Ms_Write in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_ms_write   = 1'b0;
    w_w_addr     = '0;
    w_w_data     = '0;
    w_done       = 1'b0;
    case (r_state)
      INI:   if (bus.Start) w_state_next = LDMIN;
      LDMIN: w_state_next = SCAN;
      SCAN: begin
        if (w_last) begin
          if (w_need_swap)         w_state_next = SWAP1;
          else if (r_i == c_last_i) w_state_next = DONE;
          else                     w_state_next = LDMIN;
        end
      end
      SWAP1: begin
        // M[I] is still the original value here; it moves to the min slot.
        w_ms_write   = 1'b1;
        w_w_addr     = r_min_idx;
        w_w_data     = bus.Ms_of_I;
        w_state_next = SWAP2;
      end
      SWAP2: begin
        w_ms_write   = 1'b1;
        w_w_addr     = r_i;
        w_w_data     = r_min_val;
        w_state_next = (r_i == c_last_i) ? DONE : LDMIN;
      end
      DONE: begin
        w_done = 1'b1;
        if (bus.Ack) w_state_next = INI;
      end
      default: w_state_next = UNKN;
    endcase
  end

  // Pointer / running-minimum datapath. I is held at N-2 on the final pass
  // so it never leaves the valid sort range.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_i       <= '0;
      r_j       <= '0;
      r_min_idx <= '0;
      r_min_val <= '0;
    end else begin
      case (r_state)
        INI: r_i <= '0;
        LDMIN: begin
          r_min_idx <= r_i;
          r_min_val <= bus.Ms_of_I;
          r_j       <= r_i + AW'(1);
        end
        SCAN: begin
          r_min_idx <= w_next_idx;
          r_min_val <= w_next_val;
          if (!w_last)
            r_j <= r_j + AW'(1);
          else if (!w_need_swap && (r_i != c_last_i))
            r_i <= r_i + AW'(1);
        end
        SWAP2: if (r_i != c_last_i) r_i <= r_i + AW'(1);
        default: ;
      endcase
    end
  end

`ifdef SORT_SWAP_COUNT_EN
  logic [AW+2:0] r_swap_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_swap_count <= '0;
    else if ((r_state == INI) && bus.Start)
      r_swap_count <= '0;
    else if (r_state == SWAP2)
      r_swap_count <= r_swap_count + (AW+3)'(1);
  end

  assign bus.Swap_Count = r_swap_count;
`endif

  assign bus.I        = r_i;
  assign bus.J        = r_j;
  assign bus.Ms_Write = w_ms_write;
  assign bus.W_Addr   = w_w_addr;
  assign bus.W_Data   = w_w_data;
  assign bus.Done     = w_done;

endmodule : sort_array_unsigned_sel
`default_nettype wire
